// File: rtl/ysyx_23060025_mem_resp_pkg.sv
// Shared definitions for the memory responder: FSM encoding, legal beat size,
// default memory base and the address-window check used on every access.
package ysyx_23060025_mem_resp_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_IBURST = 2'd2,
    S_DRESP  = 2'd3
  } state_t;

  localparam logic [2:0]  PSIZE_WORD        = 3'b010;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

  // True when base <= addr < base + span (span in bytes, one bit wider so a
  // window reaching the top of the address space is still expressible).
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [32:0] span);
    return (addr >= base) && ({1'b0, addr - base} < span);
  endfunction

endpackage

// File: rtl/ysyx_23060025_mem_resp_ram.sv
// DEPTH x 32 single-port RAM: combinational read, byte-strobed synchronous write.
module ysyx_23060025_mem_resp_ram #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [3:0]    wstrb,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  // NOTE: the array has no reset; contents must survive a core reset and a
  // reset loop over thousands of words would not map onto block RAM.
  logic [31:0] mem [DEPTH];

  assign rdata = mem[addr];

  // Commit only the enabled byte lanes.
  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/ysyx_23060025_mem_resp.sv
// Memory responder: round-robin arbitration between the instruction burst port
// and the data port onto one RAM, with LAT cycles from acceptance to response.
module ysyx_23060025_mem_resp
  import ysyx_23060025_mem_resp_pkg::*;
#(
  parameter int                  ADDR_LEN  = 32,
  parameter int                  DATA_LEN  = 32,
  parameter int                  DEPTH     = 4096,
  parameter logic [ADDR_LEN-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int                  LAT       = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_LEN-1:0]   inst_paddr_i,
  input  logic                  inst_psel_i,
  input  logic [7:0]            inst_plen_i,
  input  logic [2:0]            inst_psize_i,
  output logic                  inst_pvalid_o,
  output logic                  inst_plast_o,
  output logic [DATA_LEN-1:0]   inst_rdata_o,
  input  logic [ADDR_LEN-1:0]   data_paddr_i,
  input  logic                  data_psel_i,
  input  logic                  data_pwrite_i,
  input  logic [2:0]            data_psize_i,
  input  logic [DATA_LEN-1:0]   data_pwdata_i,
  input  logic [DATA_LEN/8-1:0] data_pwstrb_i,
  output logic [DATA_LEN-1:0]   data_prdata_o,
  output logic                  data_pvalid_o,
  output logic                  err_o
);

  localparam int          AW   = $clog2(DEPTH);
  localparam int          CW   = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  state_t                state, state_next;
  logic [CW-1:0]         cnt;
  logic                  grant_inst;
  logic                  last_inst;
  logic [ADDR_LEN-1:0]   inst_addr, data_addr;
  logic [7:0]            plen, beat;
  logic                  wr;
  logic [DATA_LEN-1:0]   wdata;
  logic [DATA_LEN/8-1:0] wstrb;
  logic [DATA_LEN-1:0]   inst_hold, data_hold;
  logic                  err;

  logic                  accept, pick_inst;
  logic [ADDR_LEN-1:0]   beat_addr, ram_addr_byte;
  logic [AW-1:0]         ram_idx;
  logic                  ram_hit, ram_we;
  logic [DATA_LEN-1:0]   ram_rdata, word;

  // Data wins unless it was the port granted last time.
  assign accept    = (state == S_IDLE) && (inst_psel_i || data_psel_i);
  assign pick_inst = inst_psel_i && (!data_psel_i || !last_inst);

  // The RAM port belongs to the burst while it runs, otherwise to the data side.
  assign beat_addr     = inst_addr + ADDR_LEN'({beat, 2'b00});
  assign ram_addr_byte = (state == S_IBURST) ? beat_addr : data_addr;
  assign ram_idx       = AW'((ram_addr_byte - BASE_ADDR) >> 2);
  assign ram_hit       = addr_in_range(ram_addr_byte, BASE_ADDR, SPAN);
  assign word          = ram_hit ? ram_rdata : '0;
  assign ram_we        = (state == S_DRESP) && wr && ram_hit;

  ysyx_23060025_mem_resp_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clock (clock),
    .addr  (ram_idx),
    .we    (ram_we),
    .wstrb (wstrb),
    .wdata (wdata),
    .rdata (ram_rdata)
  );

  assign inst_pvalid_o = (state == S_IBURST);
  assign inst_plast_o  = (state == S_IBURST) && (beat == plen);
  assign inst_rdata_o  = inst_pvalid_o ? word : inst_hold;
  assign data_pvalid_o = (state == S_DRESP);
  assign data_prdata_o = (data_pvalid_o && !wr) ? word : data_hold;
  assign err_o         = err;

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; LAT == 1 skips WAIT so the response lands one cycle on.
  always_comb begin
    // NOTE: defaulting first guarantees every path assigns, so no latch forms.
    state_next = state;
    unique case (state)
      S_IDLE:   if (accept) begin
                  if (LAT == 1) state_next = pick_inst ? S_IBURST : S_DRESP;
                  else          state_next = S_WAIT;
                end
      S_WAIT:   if (cnt == CW'(1)) state_next = grant_inst ? S_IBURST : S_DRESP;
      S_IBURST: if (beat == plen) state_next = S_IDLE;
      S_DRESP:  state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Request capture, wait/beat counters, held response data and sticky error.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      grant_inst <= 1'b0;
      last_inst  <= 1'b1;
      inst_addr  <= '0;
      data_addr  <= '0;
      plen       <= '0;
      beat       <= '0;
      wr         <= 1'b0;
      wdata      <= '0;
      wstrb      <= '0;
      inst_hold  <= '0;
      data_hold  <= '0;
      err        <= 1'b0;
    end else begin
      if (accept) begin
        grant_inst <= pick_inst;
        last_inst  <= pick_inst;
        cnt        <= CW'(LAT - 1);
        beat       <= '0;
        inst_addr  <= inst_paddr_i;
        plen       <= inst_plen_i;
        data_addr  <= data_paddr_i;
        wr         <= data_pwrite_i;
        wdata      <= data_pwdata_i;
        wstrb      <= data_pwstrb_i;
        if (pick_inst && (inst_psize_i != PSIZE_WORD)) err <= 1'b1;
        if (!pick_inst && (data_psize_i > 3'd2))       err <= 1'b1;
      end
      if (state == S_WAIT) cnt <= cnt - 1'b1;
      if (state == S_IBURST) begin
        beat      <= beat + 1'b1;
        inst_hold <= word;
      end
      if (state == S_DRESP && !wr) data_hold <= word;
      if ((state == S_IBURST || state == S_DRESP) && !ram_hit) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_23060025_mem_resp.sv
// Self-checking bench: directed vectors, corner sequences and random traffic
// compared against a flat-array memory model.
module tb_ysyx_23060025_mem_resp;

  localparam int          LAT   = 2;
  localparam int          DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] inst_paddr = '0;
  logic        inst_psel  = 1'b0;
  logic [7:0]  inst_plen  = '0;
  logic [2:0]  inst_psize = 3'b010;
  logic        inst_pvalid_o, inst_plast_o;
  logic [31:0] inst_rdata_o;
  logic [31:0] data_paddr  = '0;
  logic        data_psel   = 1'b0;
  logic        data_pwrite = 1'b0;
  logic [2:0]  data_psize  = 3'd2;
  logic [31:0] data_pwdata = '0;
  logic [3:0]  data_pwstrb = '0;
  logic [31:0] data_prdata_o;
  logic        data_pvalid_o, err_o;

  ysyx_23060025_mem_resp #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clock         (clock),
    .reset         (reset),
    .inst_paddr_i  (inst_paddr),
    .inst_psel_i   (inst_psel),
    .inst_plen_i   (inst_plen),
    .inst_psize_i  (inst_psize),
    .inst_pvalid_o (inst_pvalid_o),
    .inst_plast_o  (inst_plast_o),
    .inst_rdata_o  (inst_rdata_o),
    .data_paddr_i  (data_paddr),
    .data_psel_i   (data_psel),
    .data_pwrite_i (data_pwrite),
    .data_psize_i  (data_psize),
    .data_pwdata_i (data_pwdata),
    .data_pwstrb_i (data_pwstrb),
    .data_prdata_o (data_prdata_o),
    .data_pvalid_o (data_pvalid_o),
    .err_o         (err_o)
  );

  always #5 clock = ~clock;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model_mem [DEPTH];
  logic        err_exp  = 1'b0;
  logic [31:0] rd;
  int          fp;
  int          seen;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit in_map(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(((a - BASE) >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return in_map(a) ? model_mem[widx(a)] : 32'h0;
  endfunction

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1; inst_psel = 1'b0; data_psel = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    err_exp = 1'b0;
  endtask

  task automatic data_txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] st, input logic [2:0] sz, output logic [31:0] rdo);
    int lat;
    logic [31:0] exp_rd;
    exp_rd = model_read(a);
    @(negedge clock);
    data_psel = 1'b1; data_pwrite = wr; data_paddr = a;
    data_pwdata = wd; data_pwstrb = st; data_psize = sz;
    lat = -1; rdo = '0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      if (data_pvalid_o) begin lat = c; rdo = data_prdata_o; break; end
      if (c == 0) begin
        // Fields change after acceptance; the responder must use the latched copy.
        data_pwrite = ~wr; data_paddr = $urandom(); data_pwdata = $urandom();
        data_pwstrb = 4'($urandom());
      end
    end
    data_psel = 1'b0;
    check("data_latency", lat, LAT - 1);
    if (lat >= 0) begin
      if (!wr) check("data_rdata", rdo, exp_rd);
      if (!in_map(a) || sz > 3'd2) err_exp = 1'b1;
      if (wr && in_map(a))
        for (int i = 0; i < 4; i++)
          if (st[i]) model_mem[widx(a)][8*i +: 8] = wd[8*i +: 8];
    end
    @(negedge clock);
    check("data_pulse_width", data_pvalid_o, 0);
    check("data_err", err_o, err_exp);
  endtask

  task automatic inst_txn(input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] sz, input int stop_after);
    int first, nb;
    logic [31:0] ba;
    @(negedge clock);
    inst_psel = 1'b1; inst_paddr = a; inst_plen = len; inst_psize = sz;
    if (sz != 3'b010) err_exp = 1'b1;
    first = -1; nb = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      if (inst_pvalid_o) begin
        if (first < 0) first = c;
        check("inst_beat_cycle", c - first, nb);
        ba = {a[31:2], 2'b00} + 32'(nb * 4);
        check("inst_beat_data", inst_rdata_o, model_read(ba));
        check("inst_plast", inst_plast_o, (nb == int'(len)));
        if (!in_map(ba)) err_exp = 1'b1;
        nb++;
        if (inst_plast_o || nb > int'(len)) begin inst_psel = 1'b0; break; end
        if (stop_after > 0 && nb == stop_after) begin
          reset = 1'b1; inst_psel = 1'b0; break;
        end
      end
      if (c == 0) begin
        inst_paddr = $urandom(); inst_plen = 8'($urandom()); inst_psize = 3'($urandom());
      end
    end
    inst_psel = 1'b0;
    check("inst_first_latency", first, LAT - 1);
    if (stop_after <= 0) begin
      check("inst_beat_count", nb, int'(len) + 1);
      @(negedge clock);
      check("inst_no_extra_beat", inst_pvalid_o, 0);
      check("inst_err", err_o, err_exp);
    end
  endtask

  task automatic contend(output int first_port);
    int nbeats;
    bit d_done, i_done;
    logic [31:0] exp_d;
    exp_d = model_read(32'h8000_0010);
    @(negedge clock);
    data_psel = 1'b1; data_pwrite = 1'b0; data_paddr = 32'h8000_0010; data_psize = 3'd2;
    inst_psel = 1'b1; inst_paddr = 32'h8000_0100; inst_plen = 8'd1; inst_psize = 3'b010;
    first_port = -1; nbeats = 0; d_done = 1'b0; i_done = 1'b0;
    for (int c = 0; c < 60 && !(d_done && i_done); c++) begin
      @(negedge clock);
      if (data_pvalid_o) begin
        check("cont_data_rdata", data_prdata_o, exp_d);
        d_done = 1'b1; data_psel = 1'b0;
        if (first_port < 0) first_port = 0;
      end
      if (inst_pvalid_o) begin
        check("cont_inst_data", inst_rdata_o, model_read(32'h8000_0100 + 32'(nbeats * 4)));
        nbeats++;
        if (inst_plast_o) begin
          i_done = 1'b1; inst_psel = 1'b0;
          if (first_port < 0) first_port = 1;
        end
      end
    end
    data_psel = 1'b0; inst_psel = 1'b0;
    check("cont_both_served", {d_done, i_done}, 2'b11);
    check("cont_inst_beats", nbeats, 2);
    @(negedge clock);
  endtask

  initial begin
    vecs[0] = '{wr: 1'b1, addr: 32'h8000_0010, wdata: 32'hDEAD_BEEF, strb: 4'hF, exp: 32'h0};
    vecs[1] = '{wr: 1'b0, addr: 32'h8000_0010, wdata: 32'h0,         strb: 4'h0, exp: 32'hDEAD_BEEF};
    vecs[2] = '{wr: 1'b1, addr: 32'h8000_0020, wdata: 32'h1122_3344, strb: 4'hF, exp: 32'h0};
    vecs[3] = '{wr: 1'b1, addr: 32'h8000_0020, wdata: 32'hAABB_CCDD, strb: 4'b0101, exp: 32'h0};
    vecs[4] = '{wr: 1'b0, addr: 32'h8000_0020, wdata: 32'h0,         strb: 4'h0, exp: 32'h11BB_33DD};

    repeat (3) @(negedge clock);
    check("rst_inst_pvalid", inst_pvalid_o, 0);
    check("rst_inst_plast", inst_plast_o, 0);
    check("rst_inst_rdata", inst_rdata_o, 0);
    check("rst_data_pvalid", data_pvalid_o, 0);
    check("rst_data_prdata", data_prdata_o, 0);
    check("rst_err", err_o, 0);
    reset = 1'b0;

    // Preload words 0..71 and the top word so every later read has known data.
    for (int w = 0; w < 72; w++) data_txn(1'b1, BASE + 32'(4 * w), $urandom(), 4'hF, 3'd2, rd);
    data_txn(1'b1, BASE + 32'(4 * (DEPTH - 1)), $urandom(), 4'hF, 3'd2, rd);

    for (int i = 0; i < 5; i++) begin
      data_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, 3'd2, rd);
      if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
    end
    check("vec_err_clear", err_o, 0);

    inst_txn(32'h8000_0100, 8'd3, 3'b010, 0);
    inst_txn(32'h8000_0104, 8'd0, 3'b010, 0);

    apply_reset();
    contend(fp);
    check("rr_data_first_after_reset", fp, 0);
    data_txn(1'b0, 32'h8000_0020, 32'h0, 4'h0, 3'd2, rd);
    contend(fp);
    check("rr_inst_first", fp, 1);

    for (int n = 0; n < 60; n++) begin
      int kind, w;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      w    = $urandom_range(0, 68);
      a    = BASE + 32'(4 * w) + 32'($urandom_range(0, 3));
      if (kind < 4)      data_txn(1'b1, a, $urandom(), 4'($urandom()), 3'($urandom_range(0, 2)), rd);
      else if (kind < 7) data_txn(1'b0, a, 32'h0, 4'h0, 3'd2, rd);
      else if (kind < 9) inst_txn(a, 8'($urandom_range(0, 3)), 3'b010, 0);
      else begin
        a = ($urandom_range(0, 1) == 0) ? BASE - 32'd4 : BASE + 32'(4 * DEPTH);
        data_txn(1'($urandom_range(0, 1)), a, $urandom(), 4'hF, 3'd2, rd);
      end
    end

    apply_reset();
    check("err_cleared_by_reset", err_o, 0);
    data_txn(1'b0, 32'h0000_0000, 32'h0, 4'h0, 3'd2, rd);
    check("oor_read_zero", rd, 0);
    check("oor_err_set", err_o, 1);
    data_txn(1'b1, 32'h7FFF_FFFC, 32'hDEAD_BEEF, 4'hF, 3'd2, rd);
    data_txn(1'b0, BASE + 32'(4 * (DEPTH - 1)), 32'h0, 4'h0, 3'd2, rd);
    inst_txn(BASE + 32'(4 * (DEPTH - 1)), 8'd1, 3'b010, 0);
    repeat (5) @(negedge clock);
    check("err_sticky", err_o, 1);

    apply_reset();
    inst_txn(32'h8000_0100, 8'd0, 3'b011, 0);
    check("inst_psize_err", err_o, 1);
    apply_reset();
    data_txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, 3'd3, rd);
    check("data_psize_err", err_o, 1);

    apply_reset();
    inst_txn(32'h8000_0100, 8'd7, 3'b010, 3);
    @(negedge clock);
    check("midrst_inst_pvalid", inst_pvalid_o, 0);
    check("midrst_inst_plast", inst_plast_o, 0);
    check("midrst_inst_rdata", inst_rdata_o, 0);
    check("midrst_data_prdata", data_prdata_o, 0);
    reset = 1'b0; err_exp = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clock);
      if (inst_pvalid_o || data_pvalid_o) seen++;
    end
    check("midrst_no_more_pvalid", seen, 0);
    inst_txn(32'h8000_0100, 8'd7, 3'b010, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
